// File: rtl/tlb_unit_pkg.sv
// Shared constants and the probe-engine state type for the 16-entry MIPS32 TLB.
package tlb_unit_pkg;

  localparam int TLB_NUM     = 16;
  localparam int TLB_IDX_W   = 4;
  localparam int TLBP_RES_WD = 6;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  typedef enum logic [1:0] {
    TLBP_IDLE = 2'd0,
    TLBP_CMP  = 2'd1,
    TLBP_DONE = 2'd2
  } tlbp_state_e;

endpackage

// File: rtl/tlb_match.sv
// Associative lookup of one key against every TLB entry: builds the per-entry
// hit vector and reduces it to the lowest matching index.
module tlb_match
  import tlb_unit_pkg::*;
#(
  parameter int NUM   = TLB_NUM,
  parameter int IDX_W = TLB_IDX_W
) (
  input  logic [VPN2_W-1:0]           key_vpn2_i,
  input  logic [ASID_W-1:0]           key_asid_i,
  input  logic [NUM-1:0]              used_i,
  input  logic [NUM-1:0][VPN2_W-1:0]  vpn2_i,
  input  logic [NUM-1:0][ASID_W-1:0]  asid_i,
  input  logic [NUM-1:0]              g_i,
  output logic                        found_o,
  output logic [IDX_W-1:0]            index_o
);

  logic [NUM-1:0] hit;

  // An entry matches on VPN2, and on ASID unless it is global.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM; i++) begin
      hit[i] = used_i[i] && (vpn2_i[i] == key_vpn2_i) &&
               (g_i[i] || (asid_i[i] == key_asid_i));
    end
  end

  // Scan downwards so the lowest hitting index is the one left standing.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found_o = 1'b1;
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// 16-entry fully associative MIPS32 TLB: TLBWI write port, TLBR read port,
// registered TLBP probe engine and two zero-latency search ports (fetch/data).
//
// Handshake: TLBP is a one-cycle request pulse with no ready; the result is
// valid when TLBP_result[5] is high and stays valid until the next probe
// request or a write, either of which drops it in the following cycle.
//
// Entries carry a hidden occupancy bit set by any write and cleared by reset,
// so every search misses after reset regardless of the uninitialised tags.
module tlb_unit
  import tlb_unit_pkg::*;
#(
  parameter int TLBNUM = TLB_NUM,
  parameter int IDX_W  = TLB_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  // fetch search port
  input  logic [VPN2_W-1:0] s0_vpn2,
  input  logic              s0_odd_page,
  input  logic [ASID_W-1:0] s0_asid,
  output logic              s0_found,
  output logic [IDX_W-1:0]  s0_index,
  output logic [PFN_W-1:0]  s0_pfn,
  output logic [C_W-1:0]    s0_c,
  output logic              s0_d,
  output logic              s0_v,
  // data search port
  input  logic [VPN2_W-1:0] s1_vpn2,
  input  logic              s1_odd_page,
  input  logic [ASID_W-1:0] s1_asid,
  output logic              s1_found,
  output logic [IDX_W-1:0]  s1_index,
  output logic [PFN_W-1:0]  s1_pfn,
  output logic [C_W-1:0]    s1_c,
  output logic              s1_d,
  output logic              s1_v,
  // TLBWI write port
  input  logic              we,
  input  logic [IDX_W-1:0]  w_index,
  input  logic [VPN2_W-1:0] w_vpn2,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PFN_W-1:0]  w_pfn0,
  input  logic [C_W-1:0]    w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PFN_W-1:0]  w_pfn1,
  input  logic [C_W-1:0]    w_c1,
  input  logic              w_d1,
  input  logic              w_v1,
  // TLBR read port
  input  logic [IDX_W-1:0]  r_index,
  output logic [VPN2_W-1:0] r_vpn2,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PFN_W-1:0]  r_pfn0,
  output logic [C_W-1:0]    r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PFN_W-1:0]  r_pfn1,
  output logic [C_W-1:0]    r_c1,
  output logic              r_d1,
  output logic              r_v1,
  // TLBP probe engine
  input  logic              TLBP,
  input  logic [31:0]       EntryHi,
  output logic [IDX_W+1:0]  TLBP_result,
  output logic [1:0]        tlbp_state
);

  // Entry array, one flat register per field.
  logic [TLBNUM-1:0]              used_q;
  logic [TLBNUM-1:0]              g_q;
  logic [TLBNUM-1:0]              v0_q;
  logic [TLBNUM-1:0]              v1_q;
  logic [TLBNUM-1:0]              d0_q;
  logic [TLBNUM-1:0]              d1_q;
  logic [TLBNUM-1:0][VPN2_W-1:0]  vpn2_q;
  logic [TLBNUM-1:0][ASID_W-1:0]  asid_q;
  logic [TLBNUM-1:0][PFN_W-1:0]   pfn0_q;
  logic [TLBNUM-1:0][PFN_W-1:0]   pfn1_q;
  logic [TLBNUM-1:0][C_W-1:0]     c0_q;
  logic [TLBNUM-1:0][C_W-1:0]     c1_q;

  // Probe engine state.
  tlbp_state_e        state_q;
  logic [VPN2_W-1:0]  key_vpn2_q;
  logic [ASID_W-1:0]  key_asid_q;
  logic [IDX_W+1:0]   result_q;

  logic               s0_hit;
  logic [IDX_W-1:0]   s0_idx;
  logic               s1_hit;
  logic [IDX_W-1:0]   s1_idx;
  logic               p_hit;
  logic [IDX_W-1:0]   p_idx;

  // EntryHi[12:8] carries no part of the probe key.
  logic unused_entryhi_bits;
  assign unused_entryhi_bits = ^EntryHi[12:8];

  // Control bits that must be known after reset: occupancy, global, valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      used_q <= '0;
      g_q    <= '0;
      v0_q   <= '0;
      v1_q   <= '0;
    end else if (we) begin
      used_q[w_index] <= 1'b1;
      g_q[w_index]    <= w_g;
      v0_q[w_index]   <= w_v0;
      v1_q[w_index]   <= w_v1;
    end
  end

  // Tag and page data fields, written by TLBWI only.
  always_ff @(posedge clk) begin
    if (we) begin
      vpn2_q[w_index] <= w_vpn2;
      asid_q[w_index] <= w_asid;
      pfn0_q[w_index] <= w_pfn0;
      c0_q[w_index]   <= w_c0;
      d0_q[w_index]   <= w_d0;
      pfn1_q[w_index] <= w_pfn1;
      c1_q[w_index]   <= w_c1;
      d1_q[w_index]   <= w_d1;
    end
  end

  tlb_match #(.NUM(TLBNUM), .IDX_W(IDX_W)) u_match_s0 (
    .key_vpn2_i (s0_vpn2),
    .key_asid_i (s0_asid),
    .used_i     (used_q),
    .vpn2_i     (vpn2_q),
    .asid_i     (asid_q),
    .g_i        (g_q),
    .found_o    (s0_hit),
    .index_o    (s0_idx)
  );

  tlb_match #(.NUM(TLBNUM), .IDX_W(IDX_W)) u_match_s1 (
    .key_vpn2_i (s1_vpn2),
    .key_asid_i (s1_asid),
    .used_i     (used_q),
    .vpn2_i     (vpn2_q),
    .asid_i     (asid_q),
    .g_i        (g_q),
    .found_o    (s1_hit),
    .index_o    (s1_idx)
  );

  tlb_match #(.NUM(TLBNUM), .IDX_W(IDX_W)) u_match_probe (
    .key_vpn2_i (key_vpn2_q),
    .key_asid_i (key_asid_q),
    .used_i     (used_q),
    .vpn2_i     (vpn2_q),
    .asid_i     (asid_q),
    .g_i        (g_q),
    .found_o    (p_hit),
    .index_o    (p_idx)
  );

  // Fetch port: select the even or odd page of the hit entry, zeros on a miss.
  always_comb begin
    s0_found = s0_hit;
    s0_index = s0_idx;
    s0_pfn   = '0;
    s0_c     = '0;
    s0_d     = 1'b0;
    s0_v     = 1'b0;
    if (s0_hit) begin
      if (s0_odd_page) begin
        s0_pfn = pfn1_q[s0_idx];
        s0_c   = c1_q[s0_idx];
        s0_d   = d1_q[s0_idx];
        s0_v   = v1_q[s0_idx];
      end else begin
        s0_pfn = pfn0_q[s0_idx];
        s0_c   = c0_q[s0_idx];
        s0_d   = d0_q[s0_idx];
        s0_v   = v0_q[s0_idx];
      end
    end
  end

  // Data port: same selection as the fetch port.
  always_comb begin
    s1_found = s1_hit;
    s1_index = s1_idx;
    s1_pfn   = '0;
    s1_c     = '0;
    s1_d     = 1'b0;
    s1_v     = 1'b0;
    if (s1_hit) begin
      if (s1_odd_page) begin
        s1_pfn = pfn1_q[s1_idx];
        s1_c   = c1_q[s1_idx];
        s1_d   = d1_q[s1_idx];
        s1_v   = v1_q[s1_idx];
      end else begin
        s1_pfn = pfn0_q[s1_idx];
        s1_c   = c0_q[s1_idx];
        s1_d   = d0_q[s1_idx];
        s1_v   = v0_q[s1_idx];
      end
    end
  end

  assign r_vpn2 = vpn2_q[r_index];
  assign r_asid = asid_q[r_index];
  assign r_g    = g_q[r_index];
  assign r_pfn0 = pfn0_q[r_index];
  assign r_c0   = c0_q[r_index];
  assign r_d0   = d0_q[r_index];
  assign r_v0   = v0_q[r_index];
  assign r_pfn1 = pfn1_q[r_index];
  assign r_c1   = c1_q[r_index];
  assign r_d1   = d1_q[r_index];
  assign r_v1   = v1_q[r_index];

  // Probe engine: latch key, compare one cycle later, hold result until stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TLBP_IDLE;
      key_vpn2_q <= '0;
      key_asid_q <= '0;
      result_q   <= '0;
    end else begin
      case (state_q)
        TLBP_IDLE: begin
          if (TLBP) begin
            key_vpn2_q <= EntryHi[31:13];
            key_asid_q <= EntryHi[7:0];
            state_q    <= TLBP_CMP;
          end
        end
        TLBP_CMP: begin
          if (TLBP) begin
            key_vpn2_q <= EntryHi[31:13];
            key_asid_q <= EntryHi[7:0];
          end else begin
            result_q <= {1'b1, p_hit, p_idx};
            state_q  <= TLBP_DONE;
          end
        end
        TLBP_DONE: begin
          if (TLBP) begin
            key_vpn2_q <= EntryHi[31:13];
            key_asid_q <= EntryHi[7:0];
            result_q   <= '0;
            state_q    <= TLBP_CMP;
          end else if (we) begin
            result_q <= '0;
            state_q  <= TLBP_IDLE;
          end
        end
        default: begin
          result_q <= '0;
          state_q  <= TLBP_IDLE;
        end
      endcase
    end
  end

  assign TLBP_result = result_q;
  assign tlbp_state  = state_q;

endmodule
